fp_result_queue: RTL and testbench



---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_result_classify.sv | 31 +++
 rtl/fp_result_queue.sv | 112 +++++++++++
 tb/tb_fp_result_queue.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP definitions: exception flag struct, exponent constants, field helpers.
package fp_pkg;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam logic [7:0] EXP_ZERO = 8'h00;

    // Flag order is {NV,OF,UF,ZR}, so nv is the MSB of the packed value.
    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic zr;
    } fp_flags_t;

    function automatic logic fp_sign(input logic [31:0] v);
        return v[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] v);
        return v[22:0];
    endfunction

endpackage

// File: rtl/fp_result_classify.sv
// Combinational IEEE-754 single-precision result classifier.
// Produces at most one flag; an infinite result from an infinite operand is not an overflow.
module fp_result_classify
    import fp_pkg::*;
(
    input  logic [31:0] result,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output fp_flags_t   flags
);

    logic       res_exp_max;
    logic       res_exp_zero;
    logic       res_man_zero;
    logic       op_inf_nan;

    assign res_exp_max  = (fp_exp(result) == EXP_MAX);
    assign res_exp_zero = (fp_exp(result) == EXP_ZERO);
    assign res_man_zero = (fp_man(result) == 23'd0);
    assign op_inf_nan   = (fp_exp(a) == EXP_MAX) || (fp_exp(b) == EXP_MAX);

    // Decode exponent/mantissa classes into the four exception flags.
    always_comb begin
        flags    = '0;
        flags.nv = res_exp_max  && !res_man_zero;
        flags.of = res_exp_max  &&  res_man_zero && !op_inf_nan;
        flags.uf = res_exp_zero && !res_man_zero;
        flags.zr = res_exp_zero &&  res_man_zero;
    end

endmodule

// File: rtl/fp_result_queue.sv
// Output queue after the FP adder pack stage: classifies each accepted result,
// buffers {result, flags} in a DEPTH-entry FIFO and keeps sticky exception status.
module fp_result_queue
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky_flags,
    input  logic             clear_flags,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fp_flags_t             in_flags;
    logic                  push;
    logic                  pop;

    logic [31:0]           result_mem_q [DEPTH];
    logic [31:0]           result_mem_d [DEPTH];
    fp_flags_t             flags_mem_q  [DEPTH];
    fp_flags_t             flags_mem_d  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    fp_flags_t             sticky_q, sticky_d;

    fp_result_classify u_classify (
        .result (in_result),
        .a      (in_a),
        .b      (in_b),
        .flags  (in_flags)
    );

    // Handshake is derived purely from registered occupancy: no full pass-through, no empty bypass.
    assign in_ready     = (count_q != CNT_W'(DEPTH));
    assign out_valid    = (count_q != '0);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign out_result   = result_mem_q[rd_ptr_q];
    assign out_flags    = flags_mem_q[rd_ptr_q];
    assign sticky_flags = sticky_q;
    assign count        = count_q;

    // Next-state for storage, pointers, occupancy and sticky status.
    always_comb begin
        result_mem_d = result_mem_q;
        flags_mem_d  = flags_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        sticky_d     = sticky_q;

        if (push) begin
            result_mem_d[wr_ptr_q] = in_result;
            flags_mem_d[wr_ptr_q]  = in_flags;
            wr_ptr_d               = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // A clear in the same cycle as a push keeps only the new entry's flags.
        if (clear_flags && push) begin
            sticky_d = in_flags;
        end else if (clear_flags) begin
            sticky_d = '0;
        end else if (push) begin
            sticky_d = sticky_q | in_flags;
        end
    end

    // Control state register with synchronous reset that overrides any push/pop/clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Entry storage needs no reset: contents are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        result_mem_q <= result_mem_d;
        flags_mem_q  <= flags_mem_d;
    end

endmodule

// File: tb/tb_fp_result_queue.sv
// Directed self-checking bench for fp_result_queue (DEPTH=4).
module tb_fp_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic [3:0]       sticky_flags;
    logic             clear_flags;
    logic [CNT_W-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    fp_result_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .clear_flags  (clear_flags),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs settle before the edge, outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        in_result = r;
        in_a      = a;
        in_b      = b;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
        in_result = '0; in_a = '0; in_b = '0;
        #2;
        step();
        reset = 1'b0;
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_iready", 32'(in_ready), 32'd1);
        chk("rst_sticky", 32'(sticky_flags), 32'h0);

        // Basic result, latency 1
        drive(32'h40000000, 32'h3F800000, 32'h3F800000);
        step();
        in_valid = 1'b0;
        chk("basic_ovalid", 32'(out_valid), 32'd1);
        chk("basic_result", out_result, 32'h40000000);
        chk("basic_flags",  32'(out_flags), 32'h0);
        chk("basic_count",  32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("basic_pop_count",  32'(count), 32'd0);
        chk("basic_pop_ovalid", 32'(out_valid), 32'd0);

        // Overflow, then infinite operand producing infinity (no flag)
        drive(32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF);
        step();
        in_valid = 1'b0;
        chk("of_flags",  32'(out_flags), 32'h4);
        chk("of_sticky", 32'(sticky_flags), 32'h4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(32'h7F800000, 32'h7F800000, 32'h3F800000);
        step();
        in_valid = 1'b0;
        chk("infop_flags",  32'(out_flags), 32'h0);
        chk("infop_sticky", 32'(sticky_flags), 32'h4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("infop_empty", 32'(count), 32'd0);

        // NV, UF, ZR back to back after a clear
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("clr_sticky", 32'(sticky_flags), 32'h0);
        drive(32'h7FC00000, 32'h7F800000, 32'hFF800000);
        step();
        drive(32'h00000001, 32'h00000001, 32'h00000000);
        step();
        drive(32'h80000000, 32'h80000000, 32'h80000000);
        step();
        in_valid = 1'b0;
        chk("nuz_count",  32'(count), 32'd3);
        chk("nuz_sticky", 32'(sticky_flags), 32'hB);
        out_ready = 1'b1;
        chk("nv_flags",  32'(out_flags), 32'h8);
        chk("nv_result", out_result, 32'h7FC00000);
        step();
        chk("uf_flags",  32'(out_flags), 32'h2);
        chk("uf_result", out_result, 32'h00000001);
        step();
        chk("zr_flags",  32'(out_flags), 32'h1);
        chk("zr_result", out_result, 32'h80000000);
        step();
        out_ready = 1'b0;
        chk("nuz_empty", 32'(count), 32'd0);

        // Full queue with back-pressure; 5th push held until space frees
        for (int i = 1; i <= 5; i++) begin
            drive(32'(i), 32'h0, 32'h0);
            step();
            if (i == 4) chk("full_iready", 32'(in_ready), 32'd0);
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_head",  out_result, 32'h1);
        out_ready = 1'b1;
        // Pop 0x1 while full: the held push is refused.
        step();
        chk("full_pop1_count", 32'(count), 32'd3);
        chk("full_head2",      out_result, 32'h2);
        // Pop 0x2 and accept 0x5 together: count unchanged.
        step();
        in_valid = 1'b0;
        chk("full_pp_count", 32'(count), 32'd3);
        for (int i = 3; i <= 5; i++) begin
            chk("full_drain", out_result, 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("full_empty",  32'(count), 32'd0);
        chk("full_ovalid", 32'(out_valid), 32'd0);

        // Clear versus push
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        drive(32'h7FC00000, 32'h7F800000, 32'hFF800000);
        step();
        chk("cvp_sticky_nv", 32'(sticky_flags), 32'h8);
        drive(32'h00000000, 32'h00000000, 32'h00000000);
        clear_flags = 1'b1;
        step();
        in_valid = 1'b0;
        chk("cvp_sticky_push", 32'(sticky_flags), 32'h1);
        step();
        clear_flags = 1'b0;
        chk("cvp_sticky_clr", 32'(sticky_flags), 32'h0);

        // Reset mid-stream beats push and pop
        drive(32'h3F800000, 32'h3F800000, 32'h00000000);
        step();
        chk("mid_count", 32'(count), 32'd3);
        reset = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("mid_rst_count",  32'(count), 32'd0);
        chk("mid_rst_ovalid", 32'(out_valid), 32'd0);
        chk("mid_rst_iready", 32'(in_ready), 32'd1);
        chk("mid_rst_sticky", 32'(sticky_flags), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
